// File: rtl/funct_decode_queue.sv
// Multi-lane funct decoder feeding a DEPTH-entry FIFO toward issue.
// SPECIAL2 decode is built only when FUNCT_SPECIAL2_EN is defined.
module funct_decode_queue #(
    parameter int WAYS  = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WAYS-1:0]            in_lane_valid,
    input  logic [WAYS*6-1:0]          in_op,
    input  logic [WAYS*6-1:0]          in_funct,
    input  logic [WAYS*5-1:0]          in_rt,
    input  logic [WAYS*32-1:0]         in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 out_funct,
    output logic [31:0]                out_pc,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_REGIMM   = 6'b000001;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_SLTIU    = 6'b001011;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_XORI     = 6'b001110;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LB       = 6'b100000;
    localparam logic [5:0] OP_LH       = 6'b100001;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_LBU      = 6'b100100;
    localparam logic [5:0] OP_LHU      = 6'b100101;
    localparam logic [5:0] OP_SB       = 6'b101000;
    localparam logic [5:0] OP_SH       = 6'b101001;
    localparam logic [5:0] OP_SW       = 6'b101011;

    localparam logic [4:0] RT_BLTZAL   = 5'b10000;
    localparam logic [4:0] RT_BGEZAL   = 5'b10001;

    localparam logic [5:0] FUNCT_NOP   = 6'b000000;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

`ifdef FUNCT_SPECIAL2_EN
    localparam logic [5:0] FUNCT2_MADD  = 6'b000000;
    localparam logic [5:0] FUNCT2_MADDU = 6'b000001;
    localparam logic [5:0] FUNCT2_MUL   = 6'b000010;
    localparam logic [5:0] FUNCT2_MSUB  = 6'b000100;
    localparam logic [5:0] FUNCT2_MSUBU = 6'b000101;
    localparam logic [5:0] FUNCT2_CLZ   = 6'b100000;
    localparam logic [5:0] FUNCT2_CLO   = 6'b100001;
`endif

    // Result is {illegal, funct}.
    function automatic logic [6:0] decode(
        input logic [5:0] op,
        input logic [5:0] fn,
        input logic [4:0] rt
    );
        logic [6:0] r;
        r = {1'b0, FUNCT_NOP};
        unique case (op)
            OP_SPECIAL: r = {1'b0, fn};
            OP_ORI, OP_LUI, OP_JAL: r = {1'b0, FUNCT_OR};
            OP_ANDI: r = {1'b0, FUNCT_AND};
            OP_XORI: r = {1'b0, FUNCT_XOR};
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_SB, OP_SH, OP_SW, OP_ADDI: r = {1'b0, FUNCT_ADD};
            OP_ADDIU: r = {1'b0, FUNCT_ADDU};
            OP_SLTI: r = {1'b0, FUNCT_SLT};
            OP_SLTIU: r = {1'b0, FUNCT_SLTU};
            OP_REGIMM:
                if (rt == RT_BLTZAL || rt == RT_BGEZAL) r = {1'b0, FUNCT_OR};
            OP_SPECIAL2: begin
`ifdef FUNCT_SPECIAL2_EN
                unique case (fn)
                    6'b000000: r = {1'b0, FUNCT2_MADD};
                    6'b000001: r = {1'b0, FUNCT2_MADDU};
                    6'b000010: r = {1'b0, FUNCT2_MUL};
                    6'b000100: r = {1'b0, FUNCT2_MSUB};
                    6'b000101: r = {1'b0, FUNCT2_MSUBU};
                    6'b100000: r = {1'b0, FUNCT2_CLZ};
                    6'b100001: r = {1'b0, FUNCT2_CLO};
                    default:   r = {1'b1, FUNCT_NOP};
                endcase
`else
                r = {1'b1, FUNCT_NOP};
`endif
            end
            default: r = {1'b0, FUNCT_NOP};
        endcase
        return r;
    endfunction

    logic [5:0]    mem_funct [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic          mem_ill   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] cnt_q;

    logic [6:0]    dec  [WAYS];
    logic [AW-1:0] widx [WAYS];
    logic [CW-1:0] k;
    logic          enq;
    logic          deq;

    // Valid lanes are packed: each lane's slot is tail plus the
    // number of valid lanes older than it.
    always_comb begin
        k = '0;
        for (int i = 0; i < WAYS; i++) begin
            dec[i]  = decode(in_op[i*6 +: 6], in_funct[i*6 +: 6],
                             in_rt[i*5 +: 5]);
            widx[i] = tail + k[AW-1:0];
            if (in_lane_valid[i]) k = k + 1'b1;
        end
    end

    assign in_ready  = (cnt_q <= CW'(DEPTH - WAYS));
    assign out_valid = (cnt_q != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign count     = cnt_q;

    assign out_funct   = out_valid ? mem_funct[head] : FUNCT_NOP;
    assign out_pc      = out_valid ? mem_pc[head] : 32'h0;
    assign out_illegal = out_valid && mem_ill[head];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
        end else begin
            if (enq) tail <= tail + k[AW-1:0];
            if (deq) head <= head + 1'b1;
            cnt_q <= cnt_q + (enq ? k : '0) - {{(CW-1){1'b0}}, deq};
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !rst && !flush) begin
            for (int i = 0; i < WAYS; i++) begin
                if (in_lane_valid[i]) begin
                    mem_funct[widx[i]] <= dec[i][5:0];
                    mem_pc[widx[i]]    <= in_pc[i*32 +: 32];
                    mem_ill[widx[i]]   <= dec[i][6];
                end
            end
        end
    end

endmodule
